dp_ctrl: RTL



---
 rtl/dp_pkg.sv | 55 +++++
 rtl/dp_ctrl_if.sv | 30 +++
 rtl/dp_ctrl_decode.sv | 98 +++++++++
 rtl/dp_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dp_pkg : opcodes, state encoding and control-field constants for dp_ctrl
// rev 1.0
// ---------------------------------------------------------------------------
package dp_pkg;

  localparam int SHAMT_W = 3;

  localparam logic [2:0] OP_LDI  = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHLN = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOADT = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam logic [1:0] SR_IN  = 2'b00;
  localparam logic [1:0] SR_ALU = 2'b01;
  localparam logic [1:0] SR_TMP = 2'b10;

  localparam logic [1:0] ALU_XOR   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_SHL   = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [2:0] TSEL_NONE = 3'b000;
  localparam logic [2:0] TSEL_ALU  = 3'b001;
  localparam logic [2:0] TSEL_R0   = 3'b010;
  localparam logic [2:0] TSEL_B    = 3'b100;

  localparam logic [2:0] BSEL_NONE = 3'b000;

  // Register 0 has no B-mux leg, so it maps to "no source" (B reads as zero).
  function automatic logic [2:0] onehot_rs(input logic [1:0] rs);
    case (rs)
      2'd1:    onehot_rs = 3'b001;
      2'd2:    onehot_rs = 3'b010;
      2'd3:    onehot_rs = 3'b100;
      default: onehot_rs = BSEL_NONE;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    is_illegal = (op[2:1] == 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dp_ctrl_if : issuer handshake plus datapath control bundle for dp_ctrl
// rev 1.0
// ---------------------------------------------------------------------------
interface dp_ctrl_if;
  logic        start;
  logic [11:0] instr;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  sr;
  logic [1:0]  Rn;
  logic        w;
  logic [1:0]  aluop;
  logic        lt;
  logic [2:0]  tsel;
  logic [2:0]  bsel;

  modport master (
    output start, instr,
    input  busy, done, err, sr, Rn, w, aluop, lt, tsel, bsel
  );

  modport slave (
    input  start, instr,
    output busy, done, err, sr, Rn, w, aluop, lt, tsel, bsel
  );
endinterface
`default_nettype wire

// File: rtl/dp_ctrl_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dp_ctrl_decode : state + latched instruction -> datapath control outputs
// rev 1.0
// ---------------------------------------------------------------------------
module dp_ctrl_decode
  import dp_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] op,
  input  logic [1:0] rd,
  input  logic [1:0] rs,
  input  logic [2:0] shamt,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] sr,
  output logic [1:0] rn,
  output logic       w,
  output logic [1:0] aluop,
  output logic       lt,
  output logic [2:0] tsel,
  output logic [2:0] bsel
);

  always_comb begin
    busy  = (state != ST_IDLE);
    done  = 1'b0;
    err   = 1'b0;
    sr    = SR_IN;
    rn    = 2'b00;
    w     = 1'b0;
    aluop = ALU_XOR;
    lt    = 1'b0;
    tsel  = TSEL_NONE;
    bsel  = BSEL_NONE;

    unique case (state)
      ST_IDLE: ;
      ST_LOADT: begin
        lt = 1'b1;
        // Logic ops keep R0 in tmp; the rs operand arrives later via B.
        if (op == OP_XOR || op == OP_AND) begin
          tsel = TSEL_R0;
        end else if (rs != 2'd0) begin
          tsel = TSEL_B;
          bsel = onehot_rs(rs);
        end else begin
          tsel = TSEL_R0;
        end
      end
      ST_SHIFT: begin
        lt    = 1'b1;
        tsel  = TSEL_ALU;
        aluop = ALU_SHL;
      end
      ST_WB: begin
        done = 1'b1;
        if (is_illegal(op)) begin
          err = 1'b1;
        end else begin
          w  = 1'b1;
          rn = rd;
          case (op)
            OP_LDI: sr = SR_IN;
            OP_MOV: sr = SR_TMP;
            OP_XOR: begin
              sr    = SR_ALU;
              aluop = ALU_XOR;
              bsel  = onehot_rs(rs);
            end
            OP_AND: begin
              sr    = SR_ALU;
              aluop = ALU_AND;
              bsel  = onehot_rs(rs);
            end
            OP_SHL: begin
              sr    = SR_ALU;
              aluop = ALU_SHL;
            end
            OP_SHLN: begin
              // The last shift goes through the ALU on the write itself.
              if (shamt == 3'd0) begin
                sr = SR_TMP;
              end else begin
                sr    = SR_ALU;
                aluop = ALU_SHL;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dp_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dp_ctrl : multi-cycle FSM sequencing one instruction through tmp-load,
//           iterative shift and register write-back.  rev 1.0
// ---------------------------------------------------------------------------
module dp_ctrl
  import dp_pkg::*;
#(
  parameter int MAX_SHAMT = 7
) (
  input  logic      clk,
  input  logic      reset,
  dp_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_SHAMT + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [11:0]        r_instr;
  logic [11:0]        w_instr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic [2:0]         w_op;
  logic [1:0]         w_rd;
  logic [1:0]         w_rs;
  logic [SHAMT_W-1:0] w_shamt;
  logic               unused_rsvd;

  assign w_op        = r_instr[11:9];
  assign w_rd        = r_instr[8:7];
  assign w_rs        = r_instr[6:5];
  assign w_shamt     = r_instr[SHAMT_W-1:0];
  assign unused_rsvd = ^r_instr[4:3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_instr <= 12'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_instr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = r_instr;
    w_cnt_nxt   = r_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_instr_nxt = bus.instr;
          if (bus.instr[11:9] == OP_LDI || is_illegal(bus.instr[11:9]))
            w_state_nxt = ST_WB;
          else
            w_state_nxt = ST_LOADT;
        end
      end
      ST_LOADT: begin
        // LOADT already holds the operand; shamt-1 extra shifts remain.
        if (w_op == OP_SHLN && w_shamt >= 3'd2) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = CNT_W'(w_shamt) - CNT_W'(1);
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_SHIFT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1))
          w_state_nxt = ST_WB;
      end
      ST_WB: w_state_nxt = ST_IDLE;
    endcase
  end

  dp_ctrl_decode u_decode (
    .state (r_state),
    .op    (w_op),
    .rd    (w_rd),
    .rs    (w_rs),
    .shamt (w_shamt),
    .busy  (bus.busy),
    .done  (bus.done),
    .err   (bus.err),
    .sr    (bus.sr),
    .rn    (bus.Rn),
    .w     (bus.w),
    .aluop (bus.aluop),
    .lt    (bus.lt),
    .tsel  (bus.tsel),
    .bsel  (bus.bsel)
  );

endmodule
`default_nettype wire
